// File: rtl/room_sequencer.sv
// Room-to-room transition sequencer: checks exit legality against the map,
// fades out, swaps rooms, fades back in. Fading built only with ROOM_SEQ_FADE_EN.
module room_sequencer #(
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 7,
  parameter int GOAL_Y  = 7
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       exit_valid,
  input  logic [1:0] exit_dir,
  output logic       exit_ready,
  output logic       exit_nack,
  input  logic [3:0] cur_tile,
  input  logic [3:0] probe_tile,
  output logic [2:0] room_x,
  output logic [2:0] room_y,
  output logic [2:0] probe_x,
  output logic [2:0] probe_y,
  output logic [3:0] fade_level,
  output logic       player_freeze,
  output logic       win
);

  typedef enum logic [2:0] {
    S_PLAY, S_CHECK, S_FADE_OUT,
    S_SWAP, S_FADE_IN, S_WIN
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_dir;
  logic       r_grid;
  logic [2:0] r_room_x;
  logic [2:0] r_room_y;
  logic [2:0] r_probe_x;
  logic [2:0] r_probe_y;
  logic       r_nack;
  logic       w_xfer;
  logic       w_legal;
  logic       w_goal;
  logic [1:0] w_opp;
  logic [3:0] w_cur_open;
  logic [3:0] w_prb_open;
  logic [2:0] w_dst_x;
  logic [2:0] w_dst_y;
  logic       w_on_grid;

  // Open-side mask per map code: bit0 up, bit1 right, bit2 down, bit3 left
  function automatic logic [3:0] open_sides(input logic [3:0] c);
    logic [3:0] m;
    unique case (c)
      4'd0:  m = 4'b0101;
      4'd1:  m = 4'b1010;
      4'd2:  m = 4'b1001;
      4'd3:  m = 4'b0011;
      4'd4:  m = 4'b0110;
      4'd5:  m = 4'b1100;
      4'd6:  m = 4'b1111;
      4'd7:  m = 4'b0100;
      4'd8:  m = 4'b1000;
      4'd9:  m = 4'b0001;
      4'd10: m = 4'b0010;
      4'd11: m = 4'b1110;
      4'd12: m = 4'b1101;
      4'd13: m = 4'b1011;
      4'd14: m = 4'b0111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  assign w_xfer     = exit_valid & exit_ready;
  assign w_opp      = r_dir + 2'd2;
  assign w_cur_open = open_sides(cur_tile);
  assign w_prb_open = open_sides(probe_tile);
  assign w_legal    = r_grid & w_cur_open[r_dir]
                    & w_prb_open[w_opp];
  assign w_goal     = (r_room_x == 3'(GOAL_X))
                    & (r_room_y == 3'(GOAL_Y));

  // Destination room for the requested exit; edges never wrap
  always_comb begin
    w_dst_x   = r_room_x;
    w_dst_y   = r_room_y;
    w_on_grid = 1'b1;
    unique case (exit_dir)
      2'd0: begin
        w_on_grid = (r_room_y != 3'd0);
        w_dst_y   = r_room_y - 3'd1;
      end
      2'd1: begin
        w_on_grid = (r_room_x != 3'd7);
        w_dst_x   = r_room_x + 3'd1;
      end
      2'd2: begin
        w_on_grid = (r_room_y != 3'd7);
        w_dst_y   = r_room_y + 3'd1;
      end
      default: begin
        w_on_grid = (r_room_x != 3'd0);
        w_dst_x   = r_room_x - 3'd1;
      end
    endcase
  end

`ifdef ROOM_SEQ_FADE_EN
  state_t     r_prev;
  logic [3:0] r_fade;
  logic       w_frame;

  // Frames only count once the state has been held for a full cycle
  assign w_frame = frame_start & (r_state == r_prev);

  // Entry tracker for frame qualification
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_prev <= S_PLAY;
    else       r_prev <= r_state;
  end

  // Saturating fade counter driven by qualified frames
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_fade <= 4'd0;
    end else if (w_frame) begin
      if (r_state == S_FADE_OUT && r_fade != 4'd15)
        r_fade <= r_fade + 4'd1;
      else if (r_state == S_FADE_IN && r_fade != 4'd0)
        r_fade <= r_fade - 4'd1;
    end
  end

  assign fade_level = r_fade;
`else
  assign fade_level = 4'd0;
`endif

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_PLAY;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_PLAY:  if (w_xfer) w_next = S_CHECK;
`ifdef ROOM_SEQ_FADE_EN
      S_CHECK: w_next = w_legal ? S_FADE_OUT : S_PLAY;
      S_FADE_OUT:
        if (w_frame && r_fade == 4'd15) w_next = S_SWAP;
      S_SWAP:  w_next = S_FADE_IN;
      S_FADE_IN:
        if (w_frame && r_fade == 4'd0)
          w_next = w_goal ? S_WIN : S_PLAY;
`else
      S_CHECK: w_next = w_legal ? S_SWAP : S_PLAY;
      S_SWAP:  w_next = w_goal ? S_WIN : S_PLAY;
      S_FADE_OUT, S_FADE_IN: w_next = S_PLAY;
`endif
      S_WIN:   w_next = S_WIN;
      default: w_next = S_PLAY;
    endcase
  end

  // Moore outputs
  always_comb begin
    exit_ready    = (r_state == S_PLAY);
    player_freeze = (r_state != S_PLAY);
    win           = (r_state == S_WIN);
  end

  // Request latch, room load on SWAP entry, and reject pulse
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_dir     <= 2'd0;
      r_grid    <= 1'b0;
      r_room_x  <= 3'(START_X);
      r_room_y  <= 3'(START_Y);
      r_probe_x <= 3'(START_X);
      r_probe_y <= 3'(START_Y);
      r_nack    <= 1'b0;
    end else begin
      r_nack <= (r_state == S_CHECK) & ~w_legal;
      if (w_xfer) begin
        r_dir  <= exit_dir;
        r_grid <= w_on_grid;
        if (w_on_grid) begin
          r_probe_x <= w_dst_x;
          r_probe_y <= w_dst_y;
        end else begin
          r_probe_x <= r_room_x;
          r_probe_y <= r_room_y;
        end
      end
      if (r_state != S_SWAP && w_next == S_SWAP) begin
        r_room_x <= r_probe_x;
        r_room_y <= r_probe_y;
      end
    end
  end

  assign room_x    = r_room_x;
  assign room_y    = r_room_y;
  assign probe_x   = r_probe_x;
  assign probe_y   = r_probe_y;
  assign exit_nack = r_nack;

endmodule
